fp_addsub_stream: RTL and testbench
===================================

Name: fp_addsub_stream

Overview:
- Parametrised IEEE-754 binary floating-point adder/subtractor with per-operand stb/ack handshakes on inputs A and B and on output Z.
- Next generation of the fixed double-precision adder: format width is generic and the block adds a subtract mode, full special-case handling and round-to-nearest-even.
- Sits in the FPU datapath of the Pair-HMM accelerator. Multi-cycle iterative FSM; one operation in flight.

Parameters:
- EXP_W, 11, exponent field width in bits.
- MAN_W, 52, stored fraction width in bits. The total word W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset.
- input_a  in  W  operand A.
- input_a_stb  in  1  A valid.
- input_a_ack  out  1  A accepted.
- input_b  in  W  operand B.
- input_b_stb  in  1  B valid.
- input_b_ack  out  1  B accepted.
- input_op  in  1  0 = A+B, 1 = A−B; sampled in the same cycle B is accepted.
- output_z  out  W  result.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  result consumed.

Behaviour:
- Reset (rst=0 at a clk edge), including mid-operation:
  - FSM goes to GET_A.
  - input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
  - All internal registers are cleared and the in-flight operation is discarded.
- FSM states: GET_A → GET_B → UNPACK → SPECIAL → ALIGN → ADD → NORM → ROUND → PUT_Z → GET_A.
- GET_A:
  - input_a_ack=1.
  - On a cycle with ack&&stb, latch A, drop ack on the next edge, go to GET_B.
- GET_B: same rule for B. input_op is latched with B.
- Handshakes:
  - A and B are always taken strictly in order, A first.
  - A stb on B while in GET_A is ignored.
- UNPACK:
  - Split sign, exponent and fraction.
  - exp=0 means subnormal: effective exponent 1, hidden bit 0. Otherwise the hidden bit is 1.
  - For subtraction, invert B's sign.
  - Keep 3 extra low bits (guard, round, sticky).
- SPECIAL (results go directly to PUT_Z):
  - Either input NaN → canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0.
  - inf + (−inf), effective → qNaN.
  - Otherwise any inf → that inf.
  - Both zero → sign = sA AND sB(effective); else zero operand → other operand unchanged.
- ALIGN:
  - Shift the smaller-exponent mantissa right 1 bit per cycle, OR-ing shifted-out bits into sticky, and increment its exponent until exponents match.
  - Early exit when the shift count exceeds MAN_W+3 (mantissa collapses to sticky only).
- ADD:
  - Same signs: add magnitudes.
  - Different signs: subtract the smaller from the larger; result sign = sign of the larger.
  - Exact cancellation → +0 (go to PUT_Z).
- NORM:
  - On carry-out: shift right 1, keep sticky, exponent+1.
  - Otherwise while hidden bit is 0 and exponent>1: shift left 1 per cycle, exponent−1.
  - Stop at exponent 1 (subnormal result).
- ROUND:
  - Round to nearest, ties to even, using guard/round/sticky.
  - Rounding carry renormalises (exponent+1).
  - Exponent ≥ all-ones → ±inf.
  - Hidden bit 0 at exponent 1 → pack exp=0.
- PUT_Z:
  - output_z_stb=1 with output_z stable until a cycle with output_z_ack=1.
  - The next edge drops stb and goes to GET_A.
  - output_z holds its last value after stb drops.
- Latency from B accept to output_z_stb is data-dependent. Upper bound: 5 + (MAN_W+4) + (MAN_W+3) cycles.

Decomposition:
- Package fp_pkg holds:
  - the FSM state enum;
  - parametrised localparam helpers for W, EXP_MAX and canonical qNaN;
  - the GRS bit count (3).
- One natural sub-module: fp_round_pack. It is combinational and contains RNE rounding, overflow-to-inf and field packing, parametrised on EXP_W/MAN_W.

Test Plan:
- Default params, 0x40091EB851EB851F + 0x40091EB851EB851F, op=0 → 0x40191EB851EB851F (3.14+3.14=6.28).
- 0x3FF0000000000000 − 0x3FF0000000000000 → 0x0000000000000000. Also 0x7FF0000000000000 + 0xFFF0000000000000 → 0x7FF8000000000000.
- 0x3FF0000000000000 + 0x3CA0000000000000 (tie) → 0x3FF0000000000000. Also 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000.
- Subnormals: 0x0000000000000001 + 0x0000000000000001 → 0x0000000000000002. Also 0x8000000000000000 + 0x8000000000000000 → 0x8000000000000000.
- Backpressure and reset:
  - Hold output_z_ack=0 for 20 cycles → stb and output_z stay stable.
  - Pull rst low during ALIGN → all outputs 0 next edge; the next operation completes correctly.
- EXP_W=8, MAN_W=23: 0x3FC00000 + 0x40100000 → 0x40700000 (1.5+2.25=3.75). Also 0x40700000 − 0x3FC00000 → 0x40100000.

Source files
------------

// File: rtl/fp_addsub_stream_pkg.sv
// Shared types and constants for the streaming floating-point adder/subtractor.
package fp_pkg;

  // Default format: IEEE-754 binary64
  localparam int DEF_EXP_W = 11;
  localparam int DEF_MAN_W = 52;

  // Guard, round and sticky bits carried below the fraction LSB
  localparam int GRS_W = 3;

  typedef enum logic [3:0] {
    ST_GET_A   = 4'd0,
    ST_GET_B   = 4'd1,
    ST_UNPACK  = 4'd2,
    ST_SPECIAL = 4'd3,
    ST_ALIGN   = 4'd4,
    ST_ADD     = 4'd5,
    ST_NORM    = 4'd6,
    ST_ROUND   = 4'd7,
    ST_PUT_Z   = 4'd8
  } fp_state_t;

  // Total word width for a given exponent/fraction split
  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // All-ones biased exponent (inf/NaN encoding)
  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN (sign 0, exponent all-ones, fraction MSB set),
  // returned zero-extended to 128 bits; callers slice to their width
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_addsub_stream_if.sv
// Operand/result stream bundle: A and B inputs plus Z output, each stb/ack.
interface fp_addsub_stream_if
  import fp_pkg::*;
#(
  parameter int W = fp_width(DEF_EXP_W, DEF_MAN_W)
) ();

  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic [W-1:0] input_b;
  logic         input_b_stb;
  logic         input_b_ack;
  logic         input_op;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;

  // Producer/consumer side of the arithmetic block
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, input_op, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  // Arithmetic block side
  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, input_op, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );

endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, overflow to infinity and IEEE field packing.
// i_man layout: {hidden, fraction, guard, round, sticky}.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   i_sign,
  input  logic [EXP_W+1:0]       i_exp,
  input  logic [MAN_W+GRS_W:0]   i_man,
  output logic [EXP_W+MAN_W:0]   o_z
);

  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0]    EXP_MAX_V = EW'(fp_exp_max(EXP_W));
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;

  logic             w_up;
  logic [MAN_W+1:0] w_inc;
  logic [MAN_W:0]   w_man;
  logic [EW-1:0]    w_exp;

  // Round on G/R/S, renormalise a rounding carry, then pack or saturate to inf
  always_comb begin
    w_up  = i_man[2] & (i_man[1] | i_man[0] | i_man[3]);
    w_inc = {1'b0, i_man[MAN_W+GRS_W:GRS_W]} + {{(MAN_W+1){1'b0}}, w_up};
    w_man = '0;
    w_exp = '0;
    o_z   = '0;
    if (w_inc[MAN_W+1]) begin
      w_man = w_inc[MAN_W+1:1];
      w_exp = i_exp + EW'(1);
    end else begin
      w_man = w_inc[MAN_W:0];
      w_exp = i_exp;
    end
    if (w_exp >= EXP_MAX_V) begin
      o_z = {i_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (!w_man[MAN_W]) begin
      // Hidden bit clear only happens at exponent 1: subnormal encoding
      o_z = {i_sign, {EXP_W{1'b0}}, w_man[MAN_W-1:0]};
    end else begin
      o_z = {i_sign, w_exp[EXP_W-1:0], w_man[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_addsub_stream.sv
// Iterative IEEE-754 adder/subtractor with stb/ack streams on A, B and Z.
// One operation in flight; alignment and normalisation shift 1 bit/cycle.
module fp_addsub_stream
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  fp_addsub_stream_if.slave bus
);

  localparam int W  = fp_width(EXP_W, MAN_W);
  localparam int MW = MAN_W + 1 + GRS_W;   // hidden + fraction + GRS
  localparam int EW = EXP_W + 2;           // headroom for carry and rounding
  localparam int CW = $clog2(MAN_W + 5) + 1;
  localparam logic [EW-1:0]    E_ONE     = EW'(1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [127:0]     QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [CW-1:0]    CNT_LIM   = CW'(MAN_W + 3);

  fp_state_t   r_state;
  logic [W-1:0]  r_a, r_b, r_z;
  logic          r_op;
  logic          r_a_s, r_b_s, r_z_s;
  logic [EW-1:0] r_a_e, r_b_e, r_z_e;
  logic [MW-1:0] r_a_m, r_b_m;
  logic [MW:0]   r_sum;
  logic [CW-1:0] r_cnt;
  logic          r_a_ack, r_b_ack, r_z_stb;

  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [W-1:0]     w_rnd_z;

  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_frac != '0);
  assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_frac != '0);
  assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_frac == '0);
  assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_frac == '0);
  assign w_a_zero = (w_a_exp == '0) && (w_a_frac == '0);
  assign w_b_zero = (w_b_exp == '0) && (w_b_frac == '0);

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign (r_z_s),
    .i_exp  (r_z_e),
    .i_man  (r_sum[MW-1:0]),
    .o_z    (w_rnd_z)
  );

  assign bus.input_a_ack  = r_a_ack;
  assign bus.input_b_ack  = r_b_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_stb = r_z_stb;

  // Operation sequencer: handshakes, datapath steps and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_GET_A;
      r_a <= '0; r_b <= '0; r_z <= '0; r_op <= 1'b0;
      r_a_s <= 1'b0; r_b_s <= 1'b0; r_z_s <= 1'b0;
      r_a_e <= '0; r_b_e <= '0; r_z_e <= '0;
      r_a_m <= '0; r_b_m <= '0; r_sum <= '0; r_cnt <= '0;
      r_a_ack <= 1'b0; r_b_ack <= 1'b0; r_z_stb <= 1'b0;
    end else begin
      case (r_state)
        ST_GET_A: begin
          if (r_a_ack && bus.input_a_stb) begin
            r_a     <= bus.input_a;
            r_a_ack <= 1'b0;
            r_state <= ST_GET_B;
          end else begin
            r_a_ack <= 1'b1;
          end
        end
        ST_GET_B: begin
          if (r_b_ack && bus.input_b_stb) begin
            r_b     <= bus.input_b;
            r_op    <= bus.input_op;
            r_b_ack <= 1'b0;
            r_state <= ST_UNPACK;
          end else begin
            r_b_ack <= 1'b1;
          end
        end
        ST_UNPACK: begin
          // Subnormals use effective exponent 1 with a clear hidden bit
          r_a_s   <= r_a[W-1];
          r_b_s   <= r_b[W-1] ^ r_op;
          r_a_e   <= (w_a_exp == '0) ? E_ONE : EW'(w_a_exp);
          r_b_e   <= (w_b_exp == '0) ? E_ONE : EW'(w_b_exp);
          r_a_m   <= {(w_a_exp != '0), w_a_frac, {GRS_W{1'b0}}};
          r_b_m   <= {(w_b_exp != '0), w_b_frac, {GRS_W{1'b0}}};
          r_state <= ST_SPECIAL;
        end
        ST_SPECIAL: begin
          r_cnt <= '0;
          if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a_s != r_b_s))) begin
            r_z     <= QNAN;
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (w_a_inf) begin
            r_z     <= {r_a_s, EXP_ONES, {MAN_W{1'b0}}};
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (w_b_inf) begin
            r_z     <= {r_b_s, EXP_ONES, {MAN_W{1'b0}}};
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (w_a_zero && w_b_zero) begin
            r_z     <= {(r_a_s & r_b_s), {(W-1){1'b0}}};
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (w_a_zero) begin
            // B passes through with its effective (op-adjusted) sign
            r_z     <= {r_b_s, r_b[W-2:0]};
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (w_b_zero) begin
            r_z     <= r_a;
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else begin
            r_state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (r_a_e == r_b_e) begin
            r_state <= ST_ADD;
          end else if (r_cnt > CNT_LIM) begin
            // Smaller operand has shifted past every kept bit: only sticky remains
            if (r_a_e > r_b_e) begin
              r_b_m <= {{(MW-1){1'b0}}, |r_b_m};
              r_b_e <= r_a_e;
            end else begin
              r_a_m <= {{(MW-1){1'b0}}, |r_a_m};
              r_a_e <= r_b_e;
            end
            r_state <= ST_ADD;
          end else if (r_a_e > r_b_e) begin
            r_b_m <= {1'b0, r_b_m[MW-1:2], r_b_m[1] | r_b_m[0]};
            r_b_e <= r_b_e + E_ONE;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_a_m <= {1'b0, r_a_m[MW-1:2], r_a_m[1] | r_a_m[0]};
            r_a_e <= r_a_e + E_ONE;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_ADD: begin
          r_z_e <= r_a_e;
          if (r_a_s == r_b_s) begin
            r_sum   <= {1'b0, r_a_m} + {1'b0, r_b_m};
            r_z_s   <= r_a_s;
            r_state <= ST_NORM;
          end else if (r_a_m == r_b_m) begin
            // Exact cancellation always yields +0
            r_z     <= '0;
            r_z_stb <= 1'b1;
            r_state <= ST_PUT_Z;
          end else if (r_a_m > r_b_m) begin
            r_sum   <= {1'b0, r_a_m} - {1'b0, r_b_m};
            r_z_s   <= r_a_s;
            r_state <= ST_NORM;
          end else begin
            r_sum   <= {1'b0, r_b_m} - {1'b0, r_a_m};
            r_z_s   <= r_b_s;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_sum[MW]) begin
            r_sum   <= {1'b0, r_sum[MW:2], r_sum[1] | r_sum[0]};
            r_z_e   <= r_z_e + E_ONE;
            r_state <= ST_ROUND;
          end else if (!r_sum[MW-1] && (r_z_e > E_ONE)) begin
            r_sum <= {r_sum[MW-1:0], 1'b0};
            r_z_e <= r_z_e - E_ONE;
          end else begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_z     <= w_rnd_z;
          r_z_stb <= 1'b1;
          r_state <= ST_PUT_Z;
        end
        ST_PUT_Z: begin
          if (r_z_stb && bus.output_z_ack) begin
            r_z_stb <= 1'b0;
            r_state <= ST_GET_A;
          end else begin
            r_z_stb <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_GET_A;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_stream.sv
// Directed scoreboard bench for fp_addsub_stream in binary64 and binary32.
module tb_fp_addsub_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] q64[$];
  logic [31:0] q32[$];

  fp_addsub_stream_if #(.W(64)) bus64 ();
  fp_addsub_stream_if #(.W(32)) bus32 ();

  always #5 clk = ~clk;

  fp_addsub_stream u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  fp_addsub_stream #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
    end
  endtask

  task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic op, input logic [63:0] expv, input int hold);
    logic [63:0] want;
    bit seen;
    q64.push_back(expv);
    bus64.input_a = a; bus64.input_b = b; bus64.input_op = op;
    bus64.input_a_stb = 1'b1; bus64.input_b_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus64.input_a_ack) begin
        seen = 1'b1;
        check({tag, " b_ack_in_get_a"}, {63'd0, bus64.input_b_ack}, 64'd0);
      end
    end
    check({tag, " a_accept"}, {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus64.input_a_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus64.input_b_ack) seen = 1'b1;
    end
    check({tag, " b_accept"}, {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus64.input_b_stb = 1'b0;
    bus64.input_op = ~op;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus64.output_z_stb) seen = 1'b1;
    end
    check({tag, " z_stb"}, {63'd0, seen}, 64'd1);
    want = (q64.size() > 0) ? q64.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check(tag, bus64.output_z, want);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_stb"}, {63'd0, bus64.output_z_stb}, 64'd1);
      check({tag, " hold_z"}, bus64.output_z, want);
    end
    @(negedge clk);
    bus64.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus64.output_z_ack = 1'b0;
    check({tag, " stb_drop"}, {63'd0, bus64.output_z_stb}, 64'd0);
    check({tag, " z_keep"}, bus64.output_z, want);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] expv);
    logic [31:0] want;
    bit seen;
    q32.push_back(expv);
    bus32.input_a = a; bus32.input_b = b; bus32.input_op = op;
    bus32.input_a_stb = 1'b1; bus32.input_b_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus32.input_a_ack) seen = 1'b1;
    end
    check({tag, " a_accept"}, {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus32.input_a_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus32.input_b_ack) seen = 1'b1;
    end
    check({tag, " b_accept"}, {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus32.input_b_stb = 1'b0;
    bus32.input_op = ~op;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus32.output_z_stb) seen = 1'b1;
    end
    check({tag, " z_stb"}, {63'd0, seen}, 64'd1);
    want = (q32.size() > 0) ? q32.pop_front() : 32'hDEAD_DEAD;
    check(tag, {32'd0, bus32.output_z}, {32'd0, want});
    @(negedge clk);
    bus32.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus32.output_z_ack = 1'b0;
    check({tag, " stb_drop"}, {63'd0, bus32.output_z_stb}, 64'd0);
  endtask

  initial begin
    bit seen;
    bus64.input_a = 64'd0; bus64.input_b = 64'd0; bus64.input_op = 1'b0;
    bus64.input_a_stb = 1'b0; bus64.input_b_stb = 1'b0; bus64.output_z_ack = 1'b0;
    bus32.input_a = 32'd0; bus32.input_b = 32'd0; bus32.input_op = 1'b0;
    bus32.input_a_stb = 1'b0; bus32.input_b_stb = 1'b0; bus32.output_z_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst a_ack", {63'd0, bus64.input_a_ack}, 64'd0);
    check("rst b_ack", {63'd0, bus64.input_b_ack}, 64'd0);
    check("rst z_stb", {63'd0, bus64.output_z_stb}, 64'd0);
    check("rst z", bus64.output_z, 64'd0);
    check("rst32 z_stb", {63'd0, bus32.output_z_stb}, 64'd0);
    rst = 1'b1;

    // binary64 directed operations
    op64("pi_add", 64'h40091EB851EB851F, 64'h40091EB851EB851F, 1'b0, 64'h40191EB851EB851F, 0);
    op64("one_sub_one", 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 0);
    op64("inf_minf", 64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF8000000000000, 0);
    op64("rne_tie", 64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 0);
    op64("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 0);
    op64("subnorm", 64'h0000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000002, 0);
    op64("neg_zeros", 64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 0);
    op64("backpressure", 64'h40091EB851EB851F, 64'h40091EB851EB851F, 1'b0, 64'h40191EB851EB851F, 20);

    // Reset in the middle of a long alignment discards the operation
    bus64.input_a = 64'h3FF0000000000000; bus64.input_b = 64'h3CA0000000000000;
    bus64.input_op = 1'b0; bus64.input_a_stb = 1'b1; bus64.input_b_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus64.input_a_ack) seen = 1'b1;
    end
    @(posedge clk); #1;
    bus64.input_a_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus64.input_b_ack) seen = 1'b1;
    end
    check("midrst b_accept", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    bus64.input_b_stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst a_ack", {63'd0, bus64.input_a_ack}, 64'd0);
    check("midrst b_ack", {63'd0, bus64.input_b_ack}, 64'd0);
    check("midrst z_stb", {63'd0, bus64.output_z_stb}, 64'd0);
    check("midrst z", bus64.output_z, 64'd0);
    rst = 1'b1;
    op64("after_rst", 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000, 0);

    // binary32 instance
    op32("f32_add", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000);
    op32("f32_sub", 32'h40700000, 32'h3FC00000, 1'b1, 32'h40100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
